// File: rtl/fb_draw_sequencer.sv
// fb_draw_sequencer: frame-level controller between the DataGen pixel
// generator and a single-port frame buffer. It clears the buffer to a
// background colour, kicks DataGen with a start pulse, forwards DataGen's
// pixel writes as linear-address frame-buffer writes, and drops pixels that
// fall outside the visible area.
//
// Pixel handshake (valid/ready): a pixel transfers in a cycle where both
// i_px_valid and o_px_ready are high. o_px_ready does not depend on
// i_px_valid. DataGen may hold or change its pixel freely while ready is low;
// once it raises valid it keeps the pixel stable until the transfer cycle.
// An accepted in-range pixel shows up on the frame-buffer port exactly one
// cycle later; an accepted out-of-range pixel only bumps o_drop_cnt.
module fb_draw_sequencer #(
  parameter int H_RES          = 320,
  parameter int V_RES          = 240,
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 6,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_redraw,
  input  logic [DATA_W-1:0] i_bg_color,
  input  logic              i_px_valid,
  input  logic [8:0]        i_px_x,
  input  logic [7:0]        i_px_y,
  input  logic [DATA_W-1:0] i_px_data,
  output logic              o_px_ready,
  input  logic              i_gen_done,
  output logic              o_gen_start,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [DATA_W-1:0] o_fb_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [7:0]        o_drop_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_START = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

  // Last linear address of the visible frame; the clear sweep stops here.
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_RES * V_RES - 1);

  state_t              state;
  state_t              state_nx;

  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   bg_q;
  // Set by reset so the colour present on the first clock after release is
  // used directly and captured, without an extra setup cycle.
  logic                bg_pend;
  logic [DATA_W-1:0]   bg_eff;

  logic                pix_take;
  logic                pix_in_range;
  logic [ADDR_W-1:0]   pix_addr;

  logic                fb_we_nx;
  logic [ADDR_W-1:0]   fb_addr_nx;
  logic [DATA_W-1:0]   fb_data_nx;
  logic                gen_start_nx;
  logic                busy_nx;
  logic                frame_done_nx;
  logic [7:0]          drop_nx;

  assign dbg_state = state;

  // Pixels are taken in DRAW and IDLE, but never in a cycle that requests a
  // clear, so nothing gets written on top of the upcoming clear sweep.
  assign o_px_ready   = ((state == ST_DRAW) || (state == ST_IDLE)) && !i_clear;
  assign pix_take     = i_px_valid && o_px_ready;
  assign pix_in_range = (32'(i_px_x) < H_RES) && (32'(i_px_y) < V_RES);
  assign pix_addr     = ADDR_W'(i_px_y) * ADDR_W'(H_RES) + ADDR_W'(i_px_x);
  assign bg_eff       = bg_pend ? i_bg_color : bg_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      if (CLEAR_ON_RESET) state <= ST_CLEAR;
      else                state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: clear beats redraw and gen_done; a clear in progress
  // always runs to completion.
  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == CLR_LAST) state_nx = ST_START;
      end
      ST_START: begin
        state_nx = ST_DRAW;
      end
      ST_DRAW: begin
        if (i_clear)         state_nx = ST_CLEAR;
        else if (i_gen_done) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_clear)       state_nx = ST_CLEAR;
        else if (i_redraw) state_nx = ST_START;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output logic: the values every registered output takes at the next edge.
  always_comb begin
    fb_we_nx      = 1'b0;
    fb_addr_nx    = o_fb_addr;
    fb_data_nx    = o_fb_data;
    gen_start_nx  = 1'b0;
    frame_done_nx = 1'b0;
    drop_nx       = o_drop_cnt;
    busy_nx       = (state_nx != ST_IDLE);
    case (state)
      ST_CLEAR: begin
        fb_we_nx   = 1'b1;
        fb_addr_nx = clr_cnt;
        fb_data_nx = bg_eff;
      end
      ST_START: begin
        gen_start_nx = 1'b1;
      end
      ST_DRAW, ST_IDLE: begin
        if (pix_take) begin
          if (pix_in_range) begin
            fb_we_nx   = 1'b1;
            fb_addr_nx = pix_addr;
            fb_data_nx = i_px_data;
          end else if (o_drop_cnt != 8'hFF) begin
            drop_nx = o_drop_cnt + 8'd1;
          end
        end
        if ((state == ST_DRAW) && i_gen_done && !i_clear) frame_done_nx = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_fb_we      <= 1'b0;
      o_fb_addr    <= '0;
      o_fb_data    <= '0;
      o_gen_start  <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      o_fb_we      <= fb_we_nx;
      o_fb_addr    <= fb_addr_nx;
      o_fb_data    <= fb_data_nx;
      o_gen_start  <= gen_start_nx;
      o_busy       <= busy_nx;
      o_frame_done <= frame_done_nx;
      o_drop_cnt   <= drop_nx;
    end
  end

  // Clear address counter and background-colour latch.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      clr_cnt <= '0;
      bg_q    <= '0;
      bg_pend <= 1'b1;
    end else begin
      if ((state == ST_CLEAR) && (clr_cnt != CLR_LAST)) clr_cnt <= clr_cnt + ADDR_W'(1);
      else                                              clr_cnt <= '0;
      if (bg_pend || ((state != ST_CLEAR) && (state_nx == ST_CLEAR))) begin
        bg_q    <= i_bg_color;
        bg_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_draw_sequencer.sv
// Testbench for fb_draw_sequencer: a small 4x3 instance for the functional
// scenarios and a default-sized instance for the full-frame clear and the
// mid-clear reset.
module tb_fb_draw_sequencer;

  localparam int SH = 4;
  localparam int SV = 3;
  localparam int SN = SH * SV;
  localparam int BN = 320 * 240;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- small instance signals ----------------
  logic        s_rst = 1'b0, s_clear = 1'b0, s_redraw = 1'b0, s_gen_done = 1'b0;
  logic [5:0]  s_bg = 6'h15;
  logic        s_valid = 1'b0;
  logic [8:0]  s_x = '0;
  logic [7:0]  s_y = '0;
  logic [5:0]  s_pdata = '0;
  logic        s_ready, s_gen_start, s_we, s_busy, s_frame_done;
  logic [16:0] s_addr;
  logic [5:0]  s_data;
  logic [7:0]  s_drop;
  logic [1:0]  s_dbg;

  // ---------------- default instance signals ----------------
  logic        d_rst = 1'b0;
  logic        d_zero = 1'b0;
  logic [5:0]  d_bg = 6'h0C;
  logic [8:0]  d_x = '0;
  logic [7:0]  d_y = '0;
  logic [5:0]  d_pdata = '0;
  logic        d_ready, d_gen_start, d_we, d_busy, d_frame_done;
  logic [16:0] d_addr;
  logic [5:0]  d_data;
  logic [7:0]  d_drop;
  logic [1:0]  d_dbg;

  fb_draw_sequencer #(.H_RES(SH), .V_RES(SV), .ADDR_W(17), .DATA_W(6), .CLEAR_ON_RESET(1'b1)) dut_s (
    .i_clk(clk), .i_rst(s_rst), .i_clear(s_clear), .i_redraw(s_redraw), .i_bg_color(s_bg),
    .i_px_valid(s_valid), .i_px_x(s_x), .i_px_y(s_y), .i_px_data(s_pdata), .o_px_ready(s_ready),
    .i_gen_done(s_gen_done), .o_gen_start(s_gen_start), .o_fb_we(s_we), .o_fb_addr(s_addr),
    .o_fb_data(s_data), .o_busy(s_busy), .o_frame_done(s_frame_done), .o_drop_cnt(s_drop),
    .dbg_state(s_dbg)
  );

  fb_draw_sequencer dut_d (
    .i_clk(clk), .i_rst(d_rst), .i_clear(d_zero), .i_redraw(d_zero), .i_bg_color(d_bg),
    .i_px_valid(d_zero), .i_px_x(d_x), .i_px_y(d_y), .i_px_data(d_pdata), .o_px_ready(d_ready),
    .i_gen_done(d_zero), .o_gen_start(d_gen_start), .o_fb_we(d_we), .o_fb_addr(d_addr),
    .o_fb_data(d_data), .o_busy(d_busy), .o_frame_done(d_frame_done), .o_drop_cnt(d_drop),
    .dbg_state(d_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  logic [22:0] exp_q[$];       // {addr[16:0], data[5:0]} in write order
  int          drop_exp   = 0;
  int          start_exp  = 0;
  int          start_seen = 0;
  logic        mon_en     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_clear(input logic [5:0] bg);
    for (int i = 0; i < SN; i++) exp_q.push_back({17'(i), bg});
  endtask

  // One bus cycle on the small instance: drive inputs just after an edge,
  // check ready mid-cycle, update the model at the edge.
  task automatic step(input logic clr, input logic rd, input logic gd, input logic v,
                      input logic [8:0] x, input logic [7:0] y, input logic [5:0] d,
                      input logic exp_ready);
    s_clear = clr; s_redraw = rd; s_gen_done = gd; s_valid = v;
    s_x = x; s_y = y; s_pdata = d;
    @(negedge clk);
    chk("px_ready", 32'(s_ready), 32'(exp_ready));
    @(posedge clk);
    if (v && exp_ready) begin
      if (int'(x) < SH && int'(y) < SV) exp_q.push_back({17'(int'(y) * SH + int'(x)), d});
      else if (drop_exp < 255) drop_exp++;
    end
    #1;
  endtask

  task automatic idle(input logic exp_ready);
    step(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 6'd0, exp_ready);
  endtask

  // Compare process: every write against the expected queue, drop counter
  // against the model, and a tally of start pulses.
  always @(negedge clk) begin : monitor
    logic [22:0] e;
    if (mon_en) begin
      if (s_gen_start) start_seen++;
      chk("drop_cnt", 32'(s_drop), 32'(drop_exp));
      if (s_we) begin
        if (exp_q.size() == 0) begin
          chk("write_expected", 32'(s_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(s_addr), 32'(e[22:6]));
          chk("write_data", 32'(s_data), 32'(e[5:0]));
        end
      end
    end
  end

  // Small-instance clear sweep: 12 writes, then the start pulse.
  task automatic clear_sweep(input logic [5:0] bg, input bit repulse);
    for (int i = 0; i < SN; i++) begin
      step(repulse && (i == 4), 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 6'd0, 1'b0);
      chk("clr_we", 32'(s_we), 32'd1);
      chk("clr_addr", 32'(s_addr), 32'(i));
      chk("clr_data", 32'(s_data), 32'(bg));
      chk("clr_busy", 32'(s_busy), 32'd1);
    end
    idle(1'b0);
    chk("start_pulse", 32'(s_gen_start), 32'd1);
    chk("start_no_we", 32'(s_we), 32'd0);
    start_exp++;
    idle(1'b1);
    chk("start_one_cycle", 32'(s_gen_start), 32'd0);
  endtask

  task automatic small_test();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(s_we), 32'd0);
    chk("rst_start", 32'(s_gen_start), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_frame_done", 32'(s_frame_done), 32'd0);
    chk("rst_drop", 32'(s_drop), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);
    push_clear(6'h15);
    @(posedge clk); #1;
    s_rst = 1'b1;
    mon_en = 1'b1;
    clear_sweep(6'h15, 1'b0);

    // Single pixel and back-to-back pixels.
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd2, 8'd1, 6'h3F, 1'b1);
    chk("px_we", 32'(s_we), 32'd1);
    chk("px_addr_2_1", 32'(s_addr), 32'd6);
    chk("px_data_2_1", 32'(s_data), 32'h3F);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd3, 8'd2, 6'h0A, 1'b1);
    chk("px_addr_3_2", 32'(s_addr), 32'd11);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 8'd0, 6'h0B, 1'b1);
    chk("px_addr_0_0", 32'(s_addr), 32'd0);
    chk("px_data_0_0", 32'(s_data), 32'h0B);

    // Out-of-range pixels.
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd4, 8'd0, 6'h11, 1'b1);
    chk("oor_x_no_we", 32'(s_we), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 8'd3, 6'h12, 1'b1);
    chk("oor_y_no_we", 32'(s_we), 32'd0);
    chk("oor_drop_2", 32'(s_drop), 32'd2);
    idle(1'b1);

    // Frame done, pixel in IDLE, stray gen_done in IDLE, redraw.
    step(1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 8'd0, 6'd0, 1'b1);
    chk("frame_done", 32'(s_frame_done), 32'd1);
    chk("done_busy", 32'(s_busy), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 9'd1, 8'd1, 6'h22, 1'b1);
    chk("frame_done_once", 32'(s_frame_done), 32'd0);
    chk("idle_px_addr", 32'(s_addr), 32'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 6'd0, 1'b1);
    chk("redraw_busy", 32'(s_busy), 32'd1);
    chk("redraw_no_we", 32'(s_we), 32'd0);
    idle(1'b0);
    chk("redraw_start", 32'(s_gen_start), 32'd1);
    start_exp++;
    idle(1'b1);
    chk("redraw_start_end", 32'(s_gen_start), 32'd0);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 9'd300, 8'd0, 6'h01, 1'b1);
    chk("drop_sat", 32'(s_drop), 32'd255);

    // Clear in DRAW with a pixel and gen_done offered; pixel before it completes.
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd1, 8'd2, 6'h07, 1'b1);
    chk("inflight_addr", 32'(s_addr), 32'd9);
    s_bg = 6'h2A;
    push_clear(6'h2A);
    step(1'b1, 1'b0, 1'b1, 1'b1, 9'd1, 8'd1, 6'h3E, 1'b0);
    chk("clr_no_frame_done", 32'(s_frame_done), 32'd0);
    chk("clr_entry_busy", 32'(s_busy), 32'd1);
    s_bg = 6'h01;
    clear_sweep(6'h2A, 1'b1);

    // Clear and redraw together in IDLE: clear wins.
    step(1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 8'd0, 6'd0, 1'b1);
    chk("frame_done_2", 32'(s_frame_done), 32'd1);
    s_bg = 6'h33;
    push_clear(6'h33);
    step(1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 6'd0, 1'b0);
    chk("clr_redraw_no_start", 32'(s_gen_start), 32'd0);
    s_bg = 6'h00;
    clear_sweep(6'h33, 1'b0);
    repeat (3) idle(1'b1);
    mon_en = 1'b0;
  endtask

  task automatic big_test();
    int found;
    int bad;
    found = 0;
    bad = 0;
    @(posedge clk); #1;
    d_rst = 1'b1;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(negedge clk);
      if (d_we && d_addr == 17'd1000) found = 1;
    end
    chk("big_reach_1000", 32'(found), 32'd1);
    d_rst = 1'b0;
    #1;
    chk("big_rst_we", 32'(d_we), 32'd0);
    chk("big_rst_addr", 32'(d_addr), 32'd0);
    chk("big_rst_busy", 32'(d_busy), 32'd0);
    chk("big_rst_data", 32'(d_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    d_rst = 1'b1;
    @(posedge clk);
    for (int k = 0; k < BN; k++) begin
      @(negedge clk);
      if (k == 0) chk("big_first_addr", 32'(d_addr), 32'd0);
      if (k == BN - 1) chk("big_last_addr", 32'(d_addr), 32'd76799);
      if (!(d_we && 32'(d_addr) == k && d_data == 6'h0C && d_busy && !d_gen_start)) bad++;
    end
    chk("big_clear_seq_bad", 32'(bad), 32'd0);
    @(negedge clk);
    chk("big_start", 32'(d_gen_start), 32'd1);
    chk("big_start_no_we", 32'(d_we), 32'd0);
    @(negedge clk);
    chk("big_start_end", 32'(d_gen_start), 32'd0);
  endtask

  // ---------------- main ----------------
  initial begin
    fork
      small_test();
      big_test();
    join
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("start_pulses", 32'(start_seen), 32'(start_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the run is bounded well below this.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_draw_sequencer.md
Name: fb_draw_sequencer

Overview:
Frame-level controller between the DataGen pixel generator and the single-port frame buffer. After reset or on command, it clears the frame buffer to a background colour, then pulses a start to DataGen. It accepts DataGen pixel writes over a valid/ready handshake and waits for DataGen's done. It owns the only frame-buffer write port, converts (x,y) to a linear address, and drops out-of-range pixels.

Parameters:
H_RES, 320, visible pixels per line; x range 0..H_RES-1
V_RES, 240, visible lines; y range 0..V_RES-1
ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
DATA_W, 6, pixel colour width
CLEAR_ON_RESET, 1, 1: enter CLEAR after reset; 0: enter IDLE

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_clear  in  1  request a full-frame clear; sampled each cycle
i_redraw  in  1  request a new DataGen pass without clearing; honoured in IDLE only
i_bg_color  in  DATA_W  clear colour; latched on CLEAR entry
i_px_valid  in  1  DataGen pixel write valid
i_px_x  in  9  pixel x
i_px_y  in  8  pixel y
i_px_data  in  DATA_W  pixel colour
o_px_ready  out  1  pixel accepted when i_px_valid & o_px_ready
i_gen_done  in  1  DataGen pass complete (level)
o_gen_start  out  1  one-cycle start pulse to DataGen
o_fb_we  out  1  frame-buffer write enable
o_fb_addr  out  ADDR_W  frame-buffer write address
o_fb_data  out  DATA_W  frame-buffer write data
o_busy  out  1  high in CLEAR, START, DRAW
o_frame_done  out  1  one-cycle pulse on DRAW->IDLE
o_drop_cnt  out  8  count of out-of-range pixels, saturates at 255

Behaviour:
- Reset (i_rst=0, async): all outputs 0, clear counter 0, o_drop_cnt 0. State is CLEAR if CLEAR_ON_RESET=1, else IDLE. Bg colour is captured from i_bg_color on the first clock after release.
- All outputs are registered except o_px_ready, which is combinational: (state==DRAW or IDLE) & ~i_clear.
- CLEAR:
  - One write per cycle: o_fb_we=1, o_fb_addr=cnt, o_fb_data=latched bg.
  - cnt runs 0..H_RES*V_RES-1.
  - The cycle after the last address is written, go to START. Total writes = H_RES*V_RES.
  - i_clear and i_redraw are ignored in CLEAR; clear does not restart.
- START: o_gen_start=1 for exactly one cycle, then DRAW.
- DRAW:
  - Accept pixels. An accepted pixel appears on the fb port the next cycle: o_fb_we=1, o_fb_addr=y*H_RES+x (exact, ADDR_W bits), o_fb_data=i_px_data.
  - Throughput is 1 pixel/cycle.
  - i_gen_done=1 -> IDLE next cycle, with o_frame_done=1 for that one cycle.
- IDLE:
  - Pixels are still accepted and written exactly as in DRAW.
  - i_clear -> CLEAR.
  - i_redraw (without i_clear) -> START.
- Out of range (x>=H_RES or y>=V_RES): the pixel is accepted (handshake completes) but produces no write (o_fb_we=0). o_drop_cnt increments and saturates at 255.
- i_clear in DRAW or IDLE: next state CLEAR. o_px_ready is 0 that cycle, so no pixel is accepted. An in-flight registered write from the previous cycle still completes.
- i_clear and i_redraw together: clear wins.
- i_gen_done and i_clear together in DRAW: clear wins, and o_frame_done is not pulsed.
- i_gen_done outside DRAW is ignored.
- o_fb_we is 0 in any cycle with no clear write and no accepted in-range pixel from the previous cycle.
- Reset asserted mid-CLEAR or mid-DRAW: immediate return to reset state; the counter restarts from 0.

Test Plan:
- H_RES=4, V_RES=3, CLEAR_ON_RESET=1, i_bg_color=6'h15, release reset -> 12 consecutive writes, addr 0..11, data 6'h15, o_busy=1. Next cycle o_gen_start=1 for one cycle, then state DRAW.
- In DRAW, pixel (x=2,y=1,data=6'h3F) valid -> o_px_ready=1; next cycle o_fb_we=1, o_fb_addr=6, o_fb_data=6'h3F. Back-to-back pixels (3,2), (0,0) -> addr 11 then 0 on consecutive cycles.
- Pixel (x=4,y=0) and pixel (x=0,y=3) -> both accepted, o_fb_we stays 0, o_drop_cnt=2. 300 out-of-range pixels -> o_drop_cnt=255.
- In DRAW assert i_gen_done -> o_frame_done one-cycle pulse, o_busy=0. Then i_redraw -> o_gen_start pulse, no clear writes.
- In DRAW assert i_clear with i_px_valid=1 and i_gen_done=1 -> o_px_ready=0, no o_frame_done, 12 clear writes follow. i_clear re-pulsed mid-clear -> still exactly 12 writes.
- Default params: drop i_rst low at clear addr 1000 -> outputs 0 immediately. After release, the clear restarts at addr 0 and ends at addr 76799, followed by o_gen_start.
